bcd_to_binary_accumulator: RTL
==============================

# bcd_to_binary_accumulator

Sequential stage that consumes the BCD digit stream produced by the excess-3 decoding stage, one digit per handshake, most-significant digit first, and assembles each multi-digit decimal number into a binary value. A number ends with the digit flagged `in_last`. The result is then presented on a valid/ready output port with a digit count and error flags.

## Interface
Parameters:
- `DIGITS`, default 4: maximum digits accumulated per number; legal range 1..7.
- `OUT_W`, default 14: result width; must satisfy 2^OUT_W > 10^DIGITS - 1 (14 bits for 9999).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream digit valid.
- `in_ready`  out  1  stage can accept a digit.
- `in_digit`  in  4  BCD digit; codes 10..15 are invalid.
- `in_last`  in  1  digit is the final (least-significant) digit of the number.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_value`  out  OUT_W  binary value of the accumulated digits.
- `out_count`  out  3  number of digits accumulated (0..DIGITS).
- `out_error`  out  2  bit0: one or more invalid digits were seen; bit1: more than DIGITS valid digits were seen.

## Operation
- Two states: ACCUM (collecting digits) and DONE (holding the result).
- Reset state is ACCUM with acc=0, count=0, err=00.
- `in_ready` = (state==ACCUM) && rst_n.
- `out_valid` = (state==DONE).
- Digit accept condition: `in_valid && in_ready`. On each accepted digit:
  - If `in_digit` > 9: set err[0]; acc and count unchanged.
  - Else if count == DIGITS: set err[1]; the digit is discarded.
  - Else: acc <= acc*10 + in_digit, computed as (acc<<3)+(acc<<1)+digit in OUT_W bits (no overflow given the parameter rule); count <= count+1.
  - If `in_last`=1: move to DONE. The last digit's update is applied in the same edge.
- In DONE:
  - `out_value`=acc, `out_count`=count and `out_error`=err, all held stable while `out_ready`=0.
  - Input is stalled; `in_valid` is ignored.
- On `out_valid && out_ready`: return to ACCUM and clear acc, count and err in the same edge.
- A number whose only digits are invalid completes with value 0, count 0, err[0]=1.
- Both error bits can be set for the same number.
- Outputs `out_value`, `out_count` and `out_error` come straight from registers. While in ACCUM they show the partial accumulation and are don't-care to downstream.

## Timing
- Reset (`rst_n` low, at any time including mid-number or mid-DONE):
  - Immediately `out_valid`=0, `in_ready`=0, `out_value`=0, `out_count`=0, `out_error`=00, state ACCUM.
  - The partial number is discarded.
  - `in_ready` rises in the first cycle after `rst_n` deasserts.
- Throughput: one digit per cycle while in ACCUM.
- Latency: last digit accepted at edge N -> `out_valid`=1 in the cycle after edge N.
- Result accepted at edge M -> `in_ready`=1 in the cycle after edge M.
- Minimum period per number is therefore (digits + 1) cycles; a single-digit number takes 2 cycles.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Test plan
- Digits 1,2,3,4 (last on 4), `out_ready`=1 -> `out_value`=1234 (0x4D2), `out_count`=4, `out_error`=00; `out_valid` high exactly one cycle.
- Digits 7,0xB,5 (last on 5) -> `out_value`=75, `out_count`=2, `out_error`=01.
- Digits 9,8,7,6,5 (last on 5) -> `out_value`=9876, `out_count`=4, `out_error`=10.
- Digits 2,0 (last on 0) with `out_ready` held 0 for 3 cycles while `in_valid`=1 with digit 7:
  - outputs stable at value 20, count 2; `in_ready`=0; digit 7 not consumed.
  - after `out_ready`=1, the next number starts with 7.
- Digits 4,2 accepted, then `rst_n` pulsed low mid-cycle -> all outputs 0 immediately. Afterwards digit 3 (last) -> `out_value`=3, `out_count`=1.
- Back-to-back single-digit numbers 5(last), 6(last) with `in_valid`=1 and `out_ready`=1 throughout -> results 5 and 6 on alternate cycles, both with `out_error`=00.

Source files
------------

// File: rtl/bcd_to_binary_accumulator.sv
// Folds an MSD-first BCD digit stream into a binary value, with digit count and error flags.
// Result is valid the cycle after the last digit; input stalls while a result waits for out_ready.
module bcd_to_binary_accumulator #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_value,
  output logic [2:0]       out_count,
  output logic [1:0]       out_error
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  localparam logic [2:0] MAX_CNT = 3'(DIGITS);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [2:0]       count_q, count_d;
  logic [1:0]       err_q, err_d;

  logic             digit_ok;
  logic             digit_acc;
  logic [OUT_W-1:0] acc_x10_plus;

  assign digit_ok     = (in_digit <= 4'd9);
  assign digit_acc    = in_valid && in_ready;
  // acc*10 + digit as shift-add; the width rule on OUT_W guarantees no wrap.
  assign acc_x10_plus = (acc_q << 3) + (acc_q << 1) + OUT_W'(in_digit);

  assign in_ready  = (state_q == ST_ACCUM) && rst_n;
  assign out_valid = (state_q == ST_DONE);
  assign out_value = acc_q;
  assign out_count = count_q;
  assign out_error = err_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      ST_ACCUM: begin
        if (digit_acc) begin
          if (!digit_ok) begin
            err_d[0] = 1'b1;
          end else if (count_q == MAX_CNT) begin
            err_d[1] = 1'b1;
          end else begin
            acc_d   = acc_x10_plus;
            count_d = count_q + 3'd1;
          end
          if (in_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          count_d = '0;
          err_d   = '0;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule
